// File: rtl/enigma_feeder.sv
// Enigma core feeder: loads the rotor table from ROM, then streams text through the core.
// Optional watchdog on the result path is enabled with ENIGMA_FEEDER_TIMEOUT_EN.
module enigma_feeder #(
  parameter int unsigned TABLE_DEPTH = 64,
  parameter int unsigned CODE_W      = 6,
  parameter int unsigned LEN_W       = 8
) (
  input  logic              clk,
  input  logic              srstn,
  input  logic              start,
  input  logic              mode_encrypt,
  input  logic [LEN_W-1:0]  msg_len,
  output logic              rom_rd,
  output logic [5:0]        rom_addr,
  input  logic [CODE_W-1:0] rom_data,
  input  logic              txt_valid,
  input  logic [CODE_W-1:0] txt_data,
  output logic              txt_ready,
  output logic              load,
  output logic [7:0]        load_idx,
  output logic [CODE_W-1:0] code_in,
  output logic              encrypt,
  output logic              crypt_mode,
  input  logic              core_valid,
  input  logic [CODE_W-1:0] core_code,
  output logic              res_valid,
  output logic [CODE_W-1:0] res_data,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StTail,
    StGap,
    StStream,
    StDrain,
    StDone
  } state_e;

  state_e              state_q;
  logic                rom_rd_q;
  logic [5:0]          rom_addr_q;
  logic                load_q;
  logic [7:0]          load_idx_q;
  logic [CODE_W-1:0]   code_q;
  logic                encrypt_q;
  logic                crypt_mode_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    sent_q;
  logic [LEN_W-1:0]    recv_q;
  logic                res_valid_q;
  logic [CODE_W-1:0]   res_data_q;
  logic                done_q;

  logic                in_crypt;
  logic                txt_hs;
  logic                core_hs;
  logic [LEN_W-1:0]    sent_n;
  logic [LEN_W-1:0]    recv_n;
  logic                all_done;
  logic                wd_fire;

  always_comb begin
    in_crypt = (state_q == StStream) || (state_q == StDrain);
    txt_hs   = (state_q == StStream) && (sent_q != len_q) && txt_valid;
    core_hs  = in_crypt && core_valid && (recv_q != len_q);
    sent_n   = sent_q + LEN_W'(txt_hs);
    recv_n   = recv_q + LEN_W'(core_hs);
    all_done = (sent_n == len_q) && (recv_n == len_q);
  end

`ifdef ENIGMA_FEEDER_TIMEOUT_EN
  logic [4:0] idle_q;
  logic       timeout_q;

  // Sixteenth consecutive cycle without a core result while results are still owed.
  always_comb begin
    wd_fire = in_crypt && !core_valid && (idle_q == 5'd15) && (recv_q != len_q);
  end

  assign timeout = timeout_q;
`else
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state_q      <= StIdle;
      rom_rd_q     <= 1'b0;
      rom_addr_q   <= '0;
      load_q       <= 1'b0;
      load_idx_q   <= '0;
      code_q       <= '0;
      encrypt_q    <= 1'b0;
      crypt_mode_q <= 1'b0;
      len_q        <= '0;
      sent_q       <= '0;
      recv_q       <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      done_q       <= 1'b0;
`ifdef ENIGMA_FEEDER_TIMEOUT_EN
      idle_q       <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      done_q      <= 1'b0;
      res_valid_q <= 1'b0;
      // ROM data returns one cycle after the read, so load trails rom_rd by one cycle.
      load_q      <= rom_rd_q;
      if (rom_rd_q) load_idx_q <= 8'(rom_addr_q);
      if (load_q)   code_q     <= rom_data;
      if (txt_hs) begin
        code_q <= txt_data;
        sent_q <= sent_n;
      end
      if (core_hs) begin
        res_valid_q <= 1'b1;
        res_data_q  <= core_code;
        recv_q      <= recv_n;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q      <= StFetch;
            rom_rd_q     <= 1'b1;
            rom_addr_q   <= '0;
            len_q        <= msg_len;
            crypt_mode_q <= mode_encrypt;
            sent_q       <= '0;
            recv_q       <= '0;
`ifdef ENIGMA_FEEDER_TIMEOUT_EN
            timeout_q    <= 1'b0;
`endif
          end
        end
        StFetch: begin
          if (rom_addr_q == 6'(TABLE_DEPTH - 1)) begin
            rom_rd_q   <= 1'b0;
            rom_addr_q <= '0;
            state_q    <= StTail;
          end else begin
            rom_addr_q <= rom_addr_q + 6'd1;
          end
        end
        StTail: state_q <= StGap;
        StGap: begin
          if (len_q == '0) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            state_q   <= StStream;
            encrypt_q <= 1'b1;
`ifdef ENIGMA_FEEDER_TIMEOUT_EN
            idle_q    <= '0;
`endif
          end
        end
        StStream, StDrain: begin
`ifdef ENIGMA_FEEDER_TIMEOUT_EN
          if (core_valid)              idle_q <= '0;
          else if (idle_q != 5'd16)    idle_q <= idle_q + 5'd1;
`endif
          if (all_done || wd_fire) begin
            state_q   <= StDone;
            done_q    <= 1'b1;
            encrypt_q <= 1'b0;
`ifdef ENIGMA_FEEDER_TIMEOUT_EN
            if (!all_done) timeout_q <= 1'b1;
`endif
          end else if ((state_q == StStream) && (sent_n == len_q)) begin
            state_q <= StDrain;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rom_rd     = rom_rd_q;
  assign rom_addr   = rom_addr_q;
  assign txt_ready  = (state_q == StStream) && (sent_q != len_q);
  assign load       = load_q;
  assign load_idx   = load_idx_q;
  assign code_in    = load_q ? rom_data : code_q;
  assign encrypt    = encrypt_q;
  assign crypt_mode = crypt_mode_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign busy       = (state_q != StIdle);
  assign done       = done_q;

endmodule

// File: tb/tb_enigma_feeder.sv
// Bench for enigma_feeder: ROM and echo-core models, session vector table, scoreboard of results.
module tb_enigma_feeder;

  localparam int DEPTH = 64;

  logic       clk = 1'b0;
  logic       srstn = 1'b0;
  logic       start = 1'b0;
  logic       mode_encrypt = 1'b0;
  logic [7:0] msg_len = '0;
  logic       rom_rd;
  logic [5:0] rom_addr;
  logic [5:0] rom_data = '0;
  logic       txt_valid = 1'b0;
  logic [5:0] txt_data = '0;
  logic       txt_ready;
  logic       load;
  logic [7:0] load_idx;
  logic [5:0] code_in;
  logic       encrypt;
  logic       crypt_mode;
  logic       core_valid = 1'b0;
  logic [5:0] core_code = '0;
  logic       res_valid;
  logic [5:0] res_data;
  logic       busy;
  logic       done;
  logic       timeout;

  enigma_feeder dut (
    .clk          (clk),
    .srstn        (srstn),
    .start        (start),
    .mode_encrypt (mode_encrypt),
    .msg_len      (msg_len),
    .rom_rd       (rom_rd),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .txt_valid    (txt_valid),
    .txt_data     (txt_data),
    .txt_ready    (txt_ready),
    .load         (load),
    .load_idx     (load_idx),
    .code_in      (code_in),
    .encrypt      (encrypt),
    .crypt_mode   (crypt_mode),
    .core_valid   (core_valid),
    .core_code    (core_code),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .busy         (busy),
    .done         (done),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [5:0] cipher(input logic [5:0] x, input logic m);
    return m ? x + 6'd13 : x - 6'd13;
  endfunction

  function automatic logic [5:0] msg_word(input int i);
    return 6'((i * 7 + 3) % 64);
  endfunction

  logic [5:0] rom [DEPTH];
  logic [5:0] exp_q [$];

  // Synchronous ROM model.
  logic       rd_s;
  logic [5:0] a_s;
  always begin
    @(posedge clk);
    rd_s = rom_rd;
    a_s  = rom_addr;
    #1;
    if (rd_s) rom_data = rom[a_s];
  end

  // Core model: result two cycles after a text handshake, optionally dropping one.
  int         drop_at = 0;
  int         core_cnt = 0;
  logic       hs_s, hs_prev = 1'b0, cm_s, st_s;
  logic [5:0] ci_s;
  always begin
    @(posedge clk);
    hs_s = txt_valid && txt_ready;
    ci_s = code_in;
    cm_s = crypt_mode;
    st_s = start;
    #1;
    if (st_s || !srstn) core_cnt = 0;
    if (hs_prev && (core_cnt + 1 != drop_at)) begin
      core_valid = 1'b1;
      core_code  = cipher(ci_s, cm_s);
    end else begin
      core_valid = 1'b0;
    end
    if (hs_prev) core_cnt++;
    hs_prev = hs_s && srstn;
  end

  // Monitor, sampled on the falling edge.
  int         cyc = 0, exp_idx = 0, load_cnt = 0, last_load_cyc = 0, enc_cnt = 0;
  int         hs_cnt = 0, done_cnt = 0, done_cyc = 0, last_cv_cyc = 0, cur_len = 0;
  logic       prev_load = 1'b0, has_code = 1'b0;
  logic [5:0] exp_code = '0, got;
  always @(negedge clk) begin
    cyc++;
    if (start) begin
      exp_idx = 0; load_cnt = 0; enc_cnt = 0; hs_cnt = 0; done_cnt = 0;
      has_code = 1'b0; cur_len = int'(msg_len);
    end
    if (load) begin
      check("load_idx", int'(load_idx), exp_idx);
      check("load_data", int'(code_in), int'(rom[exp_idx[5:0]]));
      exp_idx++; load_cnt++; last_load_cyc = cyc;
    end
    if (prev_load && !load && busy) check("gap_encrypt", int'(encrypt), 0);
    prev_load = load;
    if (encrypt) begin
      enc_cnt++;
      if (has_code) check("code_hold", int'(code_in), int'(exp_code));
      check("ready_after_last", int'(txt_ready && (hs_cnt >= cur_len)), 0);
    end
    if (txt_valid && txt_ready) begin
      hs_cnt++; exp_code = txt_data; has_code = 1'b1;
    end
    if (res_valid) begin
      if (exp_q.size() == 0) begin
        check("res_extra", 1, 0);
      end else begin
        got = exp_q.pop_front();
        check("res_data", int'(res_data), int'(got));
      end
    end
    if (core_valid) last_cv_cyc = cyc;
    if (done) begin
      done_cnt++; done_cyc = cyc;
    end
  end

  task automatic pulse_start(input int len, input bit mode);
    @(posedge clk);
    #1;
    start = 1'b1; msg_len = 8'(len); mode_encrypt = mode;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic drive_session(input int len, input bit mode, input logic [3:0] pat,
                               input int drop);
    int sent = 0;
    int k = 0;
    drop_at = drop;
    pulse_start(len, mode);
    while (sent < len && k < 3000) begin
      @(posedge clk);
      if (txt_valid && txt_ready) begin
        exp_q.push_back(cipher(txt_data, mode));
        sent++;
      end
      #1;
      txt_valid = (sent < len) && pat[k % 4];
      txt_data  = msg_word(sent + len);
      k++;
    end
    txt_valid = 1'b0;
    check("text_sent", sent, len);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == 0) check("done_timeout", 0, 1);
  endtask

  typedef struct {
    int         len;
    bit         mode;
    logic [3:0] pat;
    int         exp_hs;
    int         exp_loads;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0] = '{len: 23, mode: 1'b1, pat: 4'b1111, exp_hs: 23, exp_loads: DEPTH};
    vecs[1] = '{len: 4,  mode: 1'b1, pat: 4'b0101, exp_hs: 4,  exp_loads: DEPTH};
    vecs[2] = '{len: 0,  mode: 1'b0, pat: 4'b1111, exp_hs: 0,  exp_loads: DEPTH};
    vecs[3] = '{len: 5,  mode: 1'b0, pat: 4'b1011, exp_hs: 5,  exp_loads: DEPTH};
    for (int i = 0; i < DEPTH; i++) rom[i] = 6'((i * 37 + 11) % 64);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rom_rd", int'(rom_rd), 0);
    check("rst_rom_addr", int'(rom_addr), 0);
    check("rst_load", int'(load), 0);
    check("rst_load_idx", int'(load_idx), 0);
    check("rst_code_in", int'(code_in), 0);
    check("rst_encrypt", int'(encrypt), 0);
    check("rst_crypt_mode", int'(crypt_mode), 0);
    check("rst_txt_ready", int'(txt_ready), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_timeout", int'(timeout), 0);
    srstn = 1'b1;

    for (int v = 0; v < 4; v++) begin
      drive_session(vecs[v].len, vecs[v].mode, vecs[v].pat, 0);
      wait_done(300);
      @(negedge clk);
      check("busy_after_done", int'(busy), 0);
      check("load_count", load_cnt, vecs[v].exp_loads);
      check("done_count", done_cnt, 1);
      check("handshakes", hs_cnt, vecs[v].exp_hs);
      check("crypt_mode", int'(crypt_mode), int'(vecs[v].mode));
      check("sb_empty", exp_q.size(), 0);
      check("timeout_clear", int'(timeout), 0);
      if (vecs[v].len == 0) begin
        check("zero_len_encrypt", enc_cnt, 0);
        check("zero_len_done_gap", done_cyc - last_load_cyc, 2);
      end
    end

    // start during the DONE cycle must be ignored
    pulse_start(0, 1'b0);
    repeat (66) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("done_before_start", done_cnt, 1);
    repeat (3) @(negedge clk);
    check("start_in_done_ignored", int'(busy), 0);

    // reset in the middle of the load phase
    pulse_start(10, 1'b1);
    begin
      int n = 0;
      while (!(load && load_idx == 8'd30) && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("reached_idx30", int'(load && load_idx == 8'd30), 1);
    end
    srstn = 1'b0;
    @(negedge clk);
    check("abort_load", int'(load), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_rom_rd", int'(rom_rd), 0);
    check("abort_no_done", int'(done), 0);
    srstn = 1'b1;
    drive_session(2, 1'b1, 4'b1111, 0);
    wait_done(300);
    @(negedge clk);
    check("reload_count", load_cnt, DEPTH);
    check("reload_sb_empty", exp_q.size(), 0);

    // core drops the third result
    drive_session(3, 1'b1, 4'b1111, 3);
`ifdef ENIGMA_FEEDER_TIMEOUT_EN
    wait_done(200);
    @(negedge clk);
    check("wd_done_delay", done_cyc - last_cv_cyc, 17);
    check("wd_timeout", int'(timeout), 1);
    check("wd_busy", int'(busy), 0);
    check("wd_missing", exp_q.size(), 1);
    exp_q.delete();
    repeat (5) @(negedge clk);
    check("wd_timeout_held", int'(timeout), 1);
    pulse_start(0, 1'b1);
    @(negedge clk);
    check("wd_timeout_cleared", int'(timeout), 0);
    wait_done(200);
`else
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("drain_wait_busy", int'(busy), 1);
    check("drain_wait_no_done", done_cnt, 0);
    check("drain_no_timeout", int'(timeout), 0);
    check("drain_missing", exp_q.size(), 1);
    exp_q.delete();
    srstn = 1'b0;
    repeat (2) @(negedge clk);
    srstn = 1'b1;
    check("drain_reset_busy", int'(busy), 0);
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
